// File: rtl/rsa_decrypt.sv
// RSA decryption engine: message_dec = ciphertext^key mod n on 128-bit operands using a bit-serial
// interleaved modular multiplier. Optional macro RSA_DEC_SKIPLZ_EN skips leading-zero exponent bits.
module rsa_decrypt (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    input  logic [127:0] n,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] message_dec
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SQ    = 3'd2,
        MUL   = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [127:0] m_r;
    logic [127:0] d_r;
    logic [127:0] n_r;
    logic [127:0] acc_r;
    logic [127:0] r_r;
    logic [6:0]   j_r;
    logic [6:0]   i_r;
    logic         busy_r;
    logic         done_r;
    logic         err_r;
    logic [127:0] msg_r;

    logic         operand_bad_s;
    logic         skip_all_s;
    logic [6:0]   i_start_s;
    logic [127:0] mul_b_s;
    logic [127:0] r_next_s;
    logic         mul_last_s;

    // One interleaved step: R = 2R mod N, then R = (R + a) mod N when the multiplier bit is set.
    // R < N < 2^128 on entry, so the 129-bit intermediate never overflows.
    function automatic logic [127:0] mod_step(input logic [127:0] r, input logic [127:0] a,
                                              input logic b_bit, input logic [127:0] nm);
        logic [128:0] t;
        logic [128:0] n_ext;
        n_ext = {1'b0, nm};
        t     = {r, 1'b0};
        if (t >= n_ext) begin
            t = t - n_ext;
        end else begin
            t = t;
        end
        if (b_bit) begin
            t = t + {1'b0, a};
            if (t >= n_ext) begin
                t = t - n_ext;
            end else begin
                t = t;
            end
        end else begin
            t = t;
        end
        return t[127:0];
    endfunction

`ifdef RSA_DEC_SKIPLZ_EN
    function automatic logic [6:0] msb_index(input logic [127:0] v);
        logic [6:0] idx;
        idx = 7'd0;
        for (int b = 0; b < 128; b++) begin
            if (v[b]) begin
                idx = b[6:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction
`endif

    // Operand screening, exponent start index and multiplier datapath.
    always_comb begin
        operand_bad_s = (n_r < 128'd2) || (m_r >= n_r);
`ifdef RSA_DEC_SKIPLZ_EN
        i_start_s     = msb_index(d_r);
        skip_all_s    = (d_r == 128'd0);
`else
        i_start_s     = 7'd127;
        skip_all_s    = 1'b0;
`endif
        mul_b_s       = (state_r == MUL) ? m_r : acc_r;
        r_next_s      = mod_step(r_r, acc_r, mul_b_s[j_r], n_r);
        mul_last_s    = (j_r == 7'd0);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = CHECK;
                else       state_s = IDLE;
            end
            CHECK: begin
                if (operand_bad_s || skip_all_s) state_s = DONE;
                else                             state_s = SQ;
            end
            SQ: begin
                if (!mul_last_s)  state_s = SQ;
                else if (d_r[i_r]) state_s = MUL;
                else              state_s = NEXT;
            end
            MUL: begin
                if (mul_last_s) state_s = NEXT;
                else            state_s = MUL;
            end
            NEXT: begin
                if (i_r == 7'd0) state_s = DONE;
                else             state_s = SQ;
            end
            DONE: begin
                if (start) state_s = DONE;
                else       state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            m_r     <= 128'd0;
            d_r     <= 128'd0;
            n_r     <= 128'd0;
            acc_r   <= 128'd0;
            r_r     <= 128'd0;
            j_r     <= 7'd0;
            i_r     <= 7'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            msg_r   <= 128'd0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == CHECK) || (state_s == SQ) || (state_s == MUL) || (state_s == NEXT);
            done_r  <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        m_r <= ciphertext;
                        d_r <= key;
                        n_r <= n;
                    end
                end
                CHECK: begin
                    if (operand_bad_s) begin
                        err_r <= 1'b1;
                        msg_r <= 128'd0;
                    end else if (skip_all_s) begin
                        err_r <= 1'b0;
                        msg_r <= 128'd1;
                    end else begin
                        err_r <= 1'b0;
                        acc_r <= 128'd1;
                        i_r   <= i_start_s;
                        r_r   <= 128'd0;
                        j_r   <= 7'd127;
                    end
                end
                SQ, MUL: begin
                    // The accumulator only changes once the whole product is formed.
                    if (mul_last_s) begin
                        acc_r <= r_next_s;
                        r_r   <= 128'd0;
                        j_r   <= 7'd127;
                    end else begin
                        r_r   <= r_next_s;
                        j_r   <= j_r - 7'd1;
                    end
                end
                NEXT: begin
                    if (i_r == 7'd0) msg_r <= acc_r;
                    else             i_r   <= i_r - 7'd1;
                end
                default: begin
                    state_r <= state_s;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign message_dec = msg_r;

endmodule

// File: tb/tb_rsa_decrypt.sv
// Self-checking bench for rsa_decrypt: expected results and latencies are queued at launch and
// compared when done rises. Latency expectations follow RSA_DEC_SKIPLZ_EN when it is defined.
module tb_rsa_decrypt;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic [127:0] n;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] message_dec;

    rsa_decrypt dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .ciphertext  (ciphertext),
        .key         (key),
        .n           (n),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .message_dec (message_dec)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [127:0] msg;
        logic         e;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   results  = 0;
    logic done_q   = 1'b0;

    localparam logic [127:0] NF = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF61;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic int exp_lat(input logic [127:0] c, input logic [127:0] d, input logic [127:0] nn);
        int k;
        if (nn < 128'd2 || c >= nn) return 1;
`ifdef RSA_DEC_SKIPLZ_EN
        if (d == 128'd0) return 1;
        k = 0;
        for (int b = 0; b < 128; b++) if (d[b]) k = b + 1;
`else
        k = 128;
`endif
        return 1 + 129 * k + 128 * $countones(d);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every rising done pops one expected result.
    always @(negedge clock) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            if (done && !done_q) begin
                if (sb_q.size() == 0) begin
                    check_val("spurious_done", 128'(sb_q.size()), 128'd1);
                end else begin
                    check_val("message_dec", message_dec, sb_q[0].msg);
                    check_val("err", 128'(err), 128'(sb_q[0].e));
                    check_val("latency", 128'(cyc - sb_q[0].t0), 128'(sb_q[0].lat));
                    check_val("busy_at_done", 128'(busy), 128'd0);
                    void'(sb_q.pop_front());
                    results <= results + 1;
                end
            end
            done_q <= done;
        end
    end

    task automatic launch(input logic [127:0] c, input logic [127:0] d, input logic [127:0] nn,
                          input logic [127:0] em, input logic ee);
        @(negedge clock);
        ciphertext = c;
        key        = d;
        n          = nn;
        start      = 1'b1;
        sb_q.push_back('{em, ee, exp_lat(c, d, nn), cyc + 1});
        @(negedge clock);
        check_val("busy_cycle1", 128'(busy), 128'd1);
        ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
        key        = {$urandom(), $urandom(), $urandom(), $urandom()};
        n          = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_result(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            if (results >= target) break;
        end
        check_val("result_count", 128'(results), 128'(target));
        @(negedge clock);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        ciphertext = 128'd0;
        key        = 128'd0;
        n          = 128'd0;
        repeat (2) @(negedge clock);
        check_val("rst_busy", 128'(busy), 128'd0);
        check_val("rst_done", 128'(done), 128'd0);
        check_val("rst_err", 128'(err), 128'd0);
        check_val("rst_msg", message_dec, 128'd0);
        reset = 1'b0;

        launch(128'd2790, 128'd2753, 128'd3233, 128'd65, 1'b0);
        start = 1'b0;
        wait_result(1, 40000);

        launch(128'd3233, 128'd2753, 128'd3233, 128'd0, 1'b1);
        start = 1'b0;
        wait_result(2, 20);
        launch(128'd0, 128'd5, 128'd1, 128'd0, 1'b1);
        start = 1'b0;
        wait_result(3, 20);
        launch(128'd0, 128'd5, 128'd0, 128'd0, 1'b1);
        start = 1'b0;
        wait_result(4, 20);

        launch(128'd5, 128'd0, 128'd3233, 128'd1, 1'b0);
        start = 1'b0;
        wait_result(5, 40000);

        // Fermat check with start toggling while busy.
        launch(128'd2, NF - 128'd1, NF, 128'd1, 1'b0);
        for (int i = 0; i < 60; i++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        start = 1'b0;
        wait_result(6, 40000);

        // Reset in the middle of an operation.
        launch(128'd2790, 128'd2753, 128'd3233, 128'd65, 1'b0);
        start = 1'b0;
        repeat (498) @(negedge clock);
        check_val("busy_before_abort", 128'(busy), 128'd1);
        reset = 1'b1;
        @(negedge clock);
        check_val("abort_busy", 128'(busy), 128'd0);
        check_val("abort_done", 128'(done), 128'd0);
        check_val("abort_err", 128'(err), 128'd0);
        check_val("abort_msg", message_dec, 128'd0);
        sb_q.delete();
        reset = 1'b0;

        // Start held high through the operation and into DONE.
        launch(128'd1234, 128'd1, 128'd3233, 128'd1234, 1'b0);
        wait_result(7, 40000);
        repeat (5) @(negedge clock);
        check_val("done_held", 128'(done), 128'd1);
        check_val("busy_held", 128'(busy), 128'd0);
        start = 1'b0;
        @(negedge clock);
        check_val("done_fall", 128'(done), 128'd0);

        launch(128'd3233, 128'd7, 128'd3233, 128'd0, 1'b1);
        start = 1'b0;
        wait_result(8, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
